alu64_seq: RTL

- Multi-cycle 64-bit operation sequencer that drives the team's existing 32-bit combinational ALU (alu32) as its operand/opcode source and consumes its result and flags.
- Accepts a 64-bit request over a valid/ready handshake and splits it into low and high 32-bit ALU passes, plus a carry/borrow fix-up pass when needed.
- Assembles the 64-bit result and c/n/z/v flags, then returns them over a valid/ready response handshake.
- Sits between the datapath controller and one alu32 instance.

---
 rtl/alu64_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu64_seq.sv
// alu64_seq: runs 64-bit ALU operations over one external 32-bit alu32.
// A request is split into a low-word pass and a high-word pass. A third
// pass fixes up the high word when the low-word add carried out or the
// low-word sub borrowed. The 64-bit result and c/n/z/v flags are returned
// over a valid/ready response handshake.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_op         64-bit operands and 3-bit opcode
//   alu_a, alu_b, alu_op         registered operands/opcode to alu32
//   alu_result, alu_c..alu_v     alu32 result and flags (only c is used)
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_c..rsp_v     assembled 64-bit result and flags
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// LO    | alu32 works on the low words
// HI    | alu32 works on the high words
// FIX   | alu32 adds/subtracts 1 to the high word (carry/borrow from LO)
// RSP   | response held until rsp_ready

module alu64_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_c,
    output logic        rsp_n,
    output logic        rsp_z,
    output logic        rsp_v
);

    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIX  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Only the high operand words are kept; the low words go straight
    // into the alu32 operand registers on the accept edge.
    logic [31:0] r_a_hi;
    logic [31:0] r_b_hi;
    logic [2:0]  r_op;
    logic [31:0] r_res_lo;
    logic        r_c_lo;
    logic        r_c_hi;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;

    logic        r_rsp_valid;
    logic [63:0] r_rsp_result;
    logic        r_rsp_c;
    logic        r_rsp_n;
    logic        r_rsp_z;
    logic        r_rsp_v;

    logic        w_need_fix;
    logic [63:0] w_fin_result;
    logic        w_fin_c;
    logic        w_fin_v;
    logic        w_load_rsp;
    logic        w_unused_flags;

    // n/z/v from alu32 are per-word and meaningless for the 64-bit result.
    assign w_unused_flags = ^{alu_n, alu_z, alu_v};

    assign w_need_fix = ((r_op == OP_ADD) &&  r_c_lo) ||
                        ((r_op == OP_SUB) && !r_c_lo);

    // Final high word comes from alu32 in the last pass (HI or FIX).
    assign w_fin_result = {alu_result, r_res_lo};
    assign w_load_rsp   = (r_state != RSP) && (w_state_nxt == RSP);

    always_comb begin
        w_fin_c = 1'b0;
        w_fin_v = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_fin_c = (r_state == FIX) ? (r_c_hi | alu_c) : alu_c;
                w_fin_v = (r_a_hi[31] == r_b_hi[31]) &&
                          (w_fin_result[63] != r_a_hi[31]);
            end
            OP_SUB: begin
                // c=1 means no borrow; a decrement pass may introduce one.
                w_fin_c = (r_state == FIX) ? (r_c_hi & alu_c) : alu_c;
                w_fin_v = (r_a_hi[31] != r_b_hi[31]) &&
                          (w_fin_result[63] != r_a_hi[31]);
            end
            default: begin
                w_fin_c = 1'b0;
                w_fin_v = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = LO;
            LO:      w_state_nxt = HI;
            HI:      w_state_nxt = w_need_fix ? FIX : RSP;
            FIX:     w_state_nxt = RSP;
            RSP:     if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (r_state == IDLE);
    end

    // Datapath: operand capture, alu32 operand sequencing, response assembly.
    // alu32 operands are loaded one edge ahead so they are stable for the
    // entire state that uses them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_hi       <= '0;
            r_b_hi       <= '0;
            r_op         <= '0;
            r_res_lo     <= '0;
            r_c_lo       <= 1'b0;
            r_c_hi       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_n      <= 1'b0;
            r_rsp_z      <= 1'b0;
            r_rsp_v      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a_hi   <= req_a[63:32];
                        r_b_hi   <= req_b[63:32];
                        r_op     <= req_op;
                        r_alu_a  <= req_a[31:0];
                        r_alu_b  <= req_b[31:0];
                        r_alu_op <= req_op;
                    end
                end
                LO: begin
                    r_res_lo <= alu_result;
                    r_c_lo   <= alu_c;
                    r_alu_a  <= r_a_hi;
                    r_alu_b  <= r_b_hi;
                end
                HI: begin
                    r_c_hi <= alu_c;
                    if (w_need_fix) begin
                        r_alu_a <= alu_result;
                        r_alu_b <= 32'h1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (w_load_rsp) begin
                r_alu_a      <= '0;
                r_alu_b      <= '0;
                r_alu_op     <= '0;
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_fin_result;
                r_rsp_c      <= w_fin_c;
                r_rsp_n      <= w_fin_result[63];
                r_rsp_z      <= (w_fin_result == 64'h0);
                r_rsp_v      <= w_fin_v;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_c      = r_rsp_c;
    assign rsp_n      = r_rsp_n;
    assign rsp_z      = r_rsp_z;
    assign rsp_v      = r_rsp_v;

endmodule
